// File: rtl/parity_check_pkg.sv
// Shared types and helpers for the parity-check arbiter.
package parity_check_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Requester-id width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational even-parity check of one data word against its received parity bit.
module parity_calc
  import parity_check_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_parity,
  output logic              o_error_c
);

  // Mismatch when the received bit differs from the XOR of the word.
  assign o_error_c = i_parity ^ (^i_data);

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one registered parity-check datapath among NREQ requesters.
// Optional per-requester sticky error log enabled by macro PCA_ERR_LOG_EN.
module parity_check_arbiter
  import parity_check_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic [NREQ-1:0]           req_parity,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_width(NREQ)-1:0] rsp_id,
  output logic                      rsp_error,
  output logic [CNT_W-1:0]          err_count
`ifdef PCA_ERR_LOG_EN
  ,
  input  logic                      err_log_clr,
  output logic [NREQ-1:0]           err_log
`endif
);

  localparam int unsigned ID_W = id_width(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_gid;
  logic [ID_W-1:0]   w_gid;
  logic              w_any;
  logic [DATA_W-1:0] r_data;
  logic              r_parity;
  logic              r_err;
  logic              w_calc_err;
  logic              w_accept;
  logic              w_hs;
  logic [CNT_W-1:0]  r_err_count;

  // (ptr + k) mod NREQ without a divider; ptr < NREQ and k < NREQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] ptr, input int unsigned k);
    logic [ID_W:0] s;
    s = {1'b0, ptr} + (ID_W+1)'(k);
    if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
    return ID_W'(s);
  endfunction

  // Round-robin pick: first valid requester starting at r_rr_ptr.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[rr_idx(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gid = rr_idx(r_rr_ptr, k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: grant strobe in IDLE, response valid in RESP.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready[w_gid] = 1'b1;
          w_accept         = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        w_hs      = rsp_ready;
      end
      default: ;
    endcase
  end

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .i_data    (r_data),
    .i_parity  (r_parity),
    .o_error_c (w_calc_err)
  );

  // Capture the granted word, register the check result, advance the pointer on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= '0;
      r_parity <= 1'b0;
      r_gid    <= '0;
      r_err    <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_data   <= req_data[w_gid*DATA_W +: DATA_W];
        r_parity <= req_parity[w_gid];
        r_gid    <= w_gid;
      end
      if (r_state == CHECK) r_err <= w_calc_err;
      if (w_hs)             r_rr_ptr <= rr_idx(r_gid, 1);
    end
  end

  // Saturating count of errored response handshakes.
  always_ff @(posedge clk) begin
    if (rst)                                         r_err_count <= '0;
    else if (w_hs && r_err && r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_W'(1);
  end

  assign rsp_id    = r_gid;
  assign rsp_error = r_err;
  assign err_count = r_err_count;

`ifdef PCA_ERR_LOG_EN
  logic [NREQ-1:0] r_err_log;
  logic [NREQ-1:0] w_log_set;

  // One-hot set mask for the requester whose errored response completes.
  always_comb begin
    w_log_set        = '0;
    w_log_set[r_gid] = w_hs & r_err;
  end

  // Sticky log; a same-cycle set survives the clear.
  always_ff @(posedge clk) begin
    if (rst) r_err_log <= '0;
    else     r_err_log <= (err_log_clr ? '0 : r_err_log) | w_log_set;
  end

  assign err_log = r_err_log;
`endif

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed self-checking bench for parity_check_arbiter (CNT_W shrunk to 3 to reach saturation).
module tb_parity_check_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_parity;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic                   rsp_error;
  logic [CNT_W-1:0]       err_count;
`ifdef PCA_ERR_LOG_EN
  logic                   err_log_clr;
  logic [NREQ-1:0]        err_log;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  parity_check_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_parity (req_parity),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_error  (rsp_error),
    .err_count  (err_count)
`ifdef PCA_ERR_LOG_EN
    ,
    .err_log_clr(err_log_clr),
    .err_log    (err_log)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction with rsp_ready high; entered at a negedge with the DUT idle.
  task automatic do_txn(input int id, input logic [31:0] data, input logic par,
                        input logic exp_err, input string tag);
    req_data[id*DATA_W +: DATA_W] = data;
    req_parity[id] = par;
    req_valid = 4'(1 << id);
    rsp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    check({tag, "_chk_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
    @(negedge clk);
    check({tag, "_idle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_parity = '0;
    rsp_ready  = 1'b1;
`ifdef PCA_ERR_LOG_EN
    err_log_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean word: 0x1 with parity 1 -> no error, count unchanged.
    do_txn(0, 32'h0000_0001, 1'b1, 1'b0, "t2");
    check("t2_err_count", 32'(err_count), 32'd0);

    // Errored word on requester 2: 0x3 has even XOR, parity 1 mismatches.
    do_txn(2, 32'h0000_0003, 1'b1, 1'b1, "t3");
    check("t3_err_count", 32'(err_count), 32'd1);

    // Reset held two cycles while a response is pending.
    req_data[1*DATA_W +: DATA_W] = 32'h0000_0001;
    req_parity[1] = 1'b0;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    check("t1_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("t1_pre_valid", 32'(rsp_valid), 32'd1);
    check("t1_pre_error", 32'(rsp_error), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_rsp_id",    32'(rsp_id),    32'd0);
    check("t1_rsp_error", 32'(rsp_error), 32'd0);
    check("t1_err_count", 32'(err_count), 32'd0);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_quiet", 32'(rsp_valid), 32'd0);
    end

    // All requesters valid: grants 0,1,2,3,0 at one per three cycles.
    for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = 32'(i);
    req_parity = 4'b0110;
    req_valid  = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      check("t4_grant", 32'(req_ready), 32'(1 << (n % 4)));
      @(negedge clk);
      check("t4_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t4_rsp_id",    32'(rsp_id),    32'(n % 4));
      check("t4_rsp_error", 32'(rsp_error), 32'd0);
      if (n == 4) rsp_ready = 1'b0;
      @(negedge clk);
    end

    // Backpressure: response frozen, no new grants while requests stay valid.
    for (int i = 0; i < 10; i++) begin
      check("t5_valid", 32'(rsp_valid), 32'd1);
      check("t5_id",    32'(rsp_id),    32'd0);
      check("t5_error", 32'(rsp_error), 32'd0);
      check("t5_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_release", 32'(rsp_valid), 32'd0);
    check("t5_err_count", 32'(err_count), 32'd0);

    // Saturation: eight errors into a 3-bit counter stop at 7.
    for (int n = 1; n <= 8; n++) begin
      do_txn(2, 32'h0000_0003, 1'b1, 1'b1, "t6");
      check("t6_err_count", 32'(err_count), 32'((n < 7) ? n : 7));
    end

`ifdef PCA_ERR_LOG_EN
    check("t6_log", 32'(err_log), 32'h4);
    // Clear coinciding with a new errored handshake on requester 1: that bit survives.
    req_data[1*DATA_W +: DATA_W] = 32'h0000_0001;
    req_parity[1] = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("t6_log_rsp", 32'(rsp_valid), 32'd1);
    err_log_clr = 1'b1;
    @(negedge clk);
    err_log_clr = 1'b0;
    check("t6_log_setwins", 32'(err_log), 32'h2);
    err_log_clr = 1'b1;
    @(negedge clk);
    err_log_clr = 1'b0;
    check("t6_log_clr", 32'(err_log), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
